// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
// Segment vectors are ordered {A,B,C,D,E,F,G} and are active-low.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
import seven_seg_pkg::*;

module seven_seg_hex_decode (
  input  logic [3:0] num,
  output seg_t       seg
);

  assign seg = SEG_TABLE[num];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit common-anode display driver: shadow registers,
// slot divider, digit index and a registered segment/anode output stage.
import seven_seg_pkg::*;

module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        E,
  output logic        F,
  output logic        G,
  output logic        DP,
  output logic [7:0]  AN,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [31:0]   data_q;
  logic [7:0]    dp_q;
  logic [7:0]    en_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          tc;

  logic [3:0]    digit;
  seg_t          digit_seg;
  logic          digit_en;
  logic          digit_dp;

  seg_t          seg_q;
  logic [7:0]    an_q;
  logic          dp_q_out;
  logic          tick_q;

  assign tc       = (cnt == CNT_LAST);
  assign digit    = data_q[{idx, 2'b00} +: 4];
  assign digit_en = en_q[idx];
  assign digit_dp = dp_q[idx];

  seven_seg_hex_decode u_decode (
    .num (digit),
    .seg (digit_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
    end else if (load) begin
      data_q <= data_in;
      dp_q   <= dp_in;
      en_q   <= en_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= tc ? '0 : cnt + 1'b1;
      tick_q <= tc && (idx == IDX_LAST);
      if (tc) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Outputs follow the current index one cycle late, so a new slot briefly
  // overlaps the previous digit instead of inserting dead time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
      dp_q_out <= 1'b1;
    end else begin
      an_q     <= digit_en ? ~(8'b1 << idx) : 8'hFF;
      seg_q    <= digit_en ? digit_seg : SEG_BLANK;
      dp_q_out <= ~(digit_dp & digit_en);
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;
  assign DP         = dp_q_out;
  assign AN         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: the driver pushes the expected post-edge outputs computed
// from elapsed-edge arithmetic; a monitor pops and compares after each edge.
module tb_seven_seg_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en_in = '0;
  logic        A, B, C, D, E, F, G, DP;
  logic [7:0]  AN;
  logic        frame_tick;

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .E          (E),
    .F          (F),
    .G          (G),
    .DP         (DP),
    .AN         (AN),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected word layout: {AN[7:0], ABCDEFG[6:0], DP, frame_tick}
  logic [16:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [6:0]  ref_seg [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference state: edges since reset release plus the displayed contents.
  int          k = 0;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dp = '0;
  logic [7:0]  m_en = '0;

  task automatic step(input logic r, input logic ld, input logic [31:0] d,
                      input logic [7:0] dp, input logic [7:0] en);
    logic [16:0] e;
    logic [7:0]  sel;
    int          slot;
    rst_n   = r;
    load    = ld;
    data_in = d;
    dp_in   = dp;
    en_in   = en;
    if (!r) begin
      e    = {8'hFF, 7'h7F, 1'b1, 1'b0};
      k    = 0;
      m_dp = '0;
      m_en = '0;
      for (int j = 0; j < 8; j++) m_dig[j] = 4'h0;
    end else begin
      slot    = (k / DIV) % 8;
      sel     = 8'h01 << slot;
      e[16:9] = m_en[slot] ? ~sel : 8'hFF;
      e[8:2]  = m_en[slot] ? ref_seg[m_dig[slot]] : 7'h7F;
      e[1]    = ~(m_dp[slot] & m_en[slot]);
      k       = k + 1;
      e[0]    = (k % FRAME) == 0;
      if (ld) begin
        for (int j = 0; j < 8; j++) m_dig[j] = d[4*j +: 4];
        m_dp = dp;
        m_en = en;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  initial begin : monitor
    logic [16:0] e;
    logic [16:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {AN, A, B, C, D, E, F, G, DP, frame_tick};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t {AN,seg,DP,tick} got %h required %h", $time, got, e);
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0);
    idle(40);

    step(1'b1, 1'b1, 32'h76543210, 8'h00, 8'hFF);
    idle(70);

    step(1'b1, 1'b1, 32'hFEDCBA98, 8'b1111_0000, 8'b0101_0101);
    idle(40);

    // Load coinciding with the digit 0 -> 1 advance.
    while ((k + 1) % FRAME != DIV) idle(1);
    step(1'b1, 1'b1, 32'h0000000F, 8'h00, 8'hFF);
    idle(40);

    // Reset while idx = 5, cnt = 2, then reload.
    while (k % FRAME != 5 * DIV + 2) idle(1);
    step(1'b0, 1'b0, '0, '0, '0);
    idle(3);
    step(1'b1, 1'b1, 32'h89ABCDEF, 8'hA5, 8'hFF);
    idle(40);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 149) == 0)
        step(1'b0, 1'($urandom), $urandom, 8'($urandom), 8'($urandom));
      else if ($urandom_range(0, 9) == 0)
        step(1'b1, 1'b1, $urandom, 8'($urandom), 8'($urandom));
      else
        idle(1);
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
